rom_bank: RTL and testbench



---
 rtl/rom_bank_pkg.sv | 27 ++
 rtl/rom_bank_array.sv | 50 +++++
 rtl/rom_bank.sv | 169 ++++++++++++++++
 tb/tb_rom_bank.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_bank_pkg.sv
// rom_bank_pkg -- shared definitions for the rom_bank memory bank.
//
// Holds the default widths, the legal READ_LAT range, the byte-offset width
// helper and the control half of the response-stage bundle. A full stage is
// laid out as {vld, err, data}; the data field width depends on the bank's
// DATA_W, so the top module appends it to rsp_ctl_t.
//
// Optional feature macro used by the bank: ROM_BANK_WPROT_EN (write protect).
package rom_bank_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 32;
   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 4;

   // Number of low address bits that select a byte inside one word.
   function automatic int off_w(input int strb_w);
      return $clog2(strb_w);
   endfunction

   // Leading part of every response pipeline stage: {vld, err}.
   typedef struct packed {
      logic vld;
      logic err;
   } rsp_ctl_t;

endpackage

// File: rtl/rom_bank_array.sv
// rom_bank_array -- plain single-port synchronous RAM with byte strobes.
//
// Kept free of any handshake logic so it maps onto block RAM. One access per
// enabled cycle: strobed bytes are written and the old word is registered
// onto rdata (read-first). With en low the array is untouched and rdata holds.
//
// Ports:
//   clk    in   clock
//   en     in   access enable
//   we     in   write enable (qualified by en)
//   strb   in   byte enables for writes
//   idx    in   word index, must be < DEPTH when en is high
//   wdata  in   write data
//   rdata  out  registered read data
module rom_bank_array
   import rom_bank_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 4096,
   parameter int IDX_W  = 12,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [STRB_W-1:0] strb,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (strb[b]) begin
                  mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
               end
            end
         end
         rdata_q <= mem_q[idx];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/rom_bank.sv
// rom_bank -- pipelined, parametrised instruction/data memory bank.
//
// Valid/ready request and response channels around a strobed RAM. Requests
// are checked for misalignment and range, writes commit in the acceptance
// cycle, and every request produces exactly one response READ_LAT cycles
// later. A stalled response (rsp_valid && !rsp_ready) freezes the whole
// pipeline and drops req_ready.
//
// Optional feature: define ROM_BANK_WPROT_EN to add the wp_lock input and a
// sticky lock flop that rejects all writes (with rsp_err) until rst.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   wp_lock    in   set write lock (only with ROM_BANK_WPROT_EN)
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle when valid
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   req_strb   in   write byte enables
//   rsp_valid  out  response present
//   rsp_ready  in   consumer takes the response
//   rsp_rdata  out  read data, 0 for writes and errors
//   rsp_err    out  misaligned, out-of-range or locked write
module rom_bank
   import rom_bank_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DEPTH    = 4096,
   parameter int READ_LAT = 1,
   localparam int STRB_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
`ifdef ROM_BANK_WPROT_EN
   input  logic              wp_lock,
`endif
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [STRB_W-1:0] req_strb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int OFF_W  = off_w(STRB_W);
   localparam int WIDX_W = ADDR_W - OFF_W;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      rsp_ctl_t          ctl;
      logic [DATA_W-1:0] data;
   } stage_t;

   logic [WIDX_W-1:0] word_idx;
   logic              misalign;
   logic              out_of_range;
   logic              wr_block;
   logic              req_err;
   logic              stall;
   logic              accept;
   logic [DATA_W-1:0] ram_rdata;
   stage_t            st_p0;
   stage_t            st_last;

   assign word_idx     = req_addr[ADDR_W-1:OFF_W];
   assign misalign     = |req_addr[OFF_W-1:0];
   assign out_of_range = (word_idx >= WIDX_W'(DEPTH));

`ifdef ROM_BANK_WPROT_EN
   logic lock_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q <= 1'b0;
      end else if (wp_lock) begin
         lock_q <= 1'b1;
      end
   end

   assign wr_block = req_we & lock_q;
`else
   assign wr_block = 1'b0;
`endif

   assign req_err   = misalign | out_of_range | wr_block;
   assign stall     = rsp_valid & ~rsp_ready;
   assign req_ready = ~stall;
   assign accept    = req_valid & req_ready;

   // The array is only touched on acceptance, so it is idle during a stall
   // and its registered rdata doubles as the stage-0 data register.
   rom_bank_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (accept),
      .we    (req_we & ~req_err),
      .strb  (req_strb),
      .idx   (word_idx[IDX_W-1:0]),
      .wdata (req_wdata),
      .rdata (ram_rdata)
   );

   // ---- stage 0: capture request flags alongside the array read ----
   logic vld_p0_q;
   logic err_p0_q;
   logic zero_p0_q;   // writes and errors return zero data

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0_q <= 1'b0;
      end else if (!stall) begin
         vld_p0_q <= accept;
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         err_p0_q  <= req_err;
         zero_p0_q <= req_we | req_err;
      end
   end

   always_comb begin
      st_p0         = '0;
      st_p0.ctl.vld = vld_p0_q;
      st_p0.ctl.err = err_p0_q;
      if (!zero_p0_q) begin
         st_p0.data = ram_rdata;
      end
   end

   // ---- stages 1..READ_LAT-1: delay line, frozen as a whole on stall ----
   if (READ_LAT == 1) begin : g_lat1
      assign st_last = st_p0;
   end else begin : g_pipe
      stage_t stg_q [READ_LAT-1];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < READ_LAT-1; i++) begin
               stg_q[i].ctl.vld <= 1'b0;
            end
         end else if (!stall) begin
            stg_q[0] <= st_p0;
            for (int i = 1; i < READ_LAT-1; i++) begin
               stg_q[i] <= stg_q[i-1];
            end
         end
      end

      assign st_last = stg_q[READ_LAT-2];
   end

   // ---- output stage: data and error are qualified by valid ----
   assign rsp_valid = st_last.ctl.vld;
   assign rsp_err   = st_last.ctl.vld & st_last.ctl.err;
   assign rsp_rdata = st_last.ctl.vld ? st_last.data : '0;

endmodule

// File: tb/tb_rom_bank.sv
// tb_rom_bank -- self-checking bench for rom_bank (DATA_W=32, READ_LAT=2,
// DEPTH=48). Table-driven single transactions, hand sequences for
// backpressure and reset, then randomized traffic against a word-array model.
module tb_rom_bank;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 48;
   localparam int RL    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [3:0]    req_strb;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
`ifdef ROM_BANK_WPROT_EN
   logic          wp_lock;
`endif

   always #5 clk = ~clk;

   rom_bank #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .DEPTH    (DEPTH),
      .READ_LAT (RL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef ROM_BANK_WPROT_EN
      .wp_lock   (wp_lock),
`endif
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_strb  (req_strb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---- reference model: word array plus lock flag ----
   logic [31:0] mem_m [DEPTH];
   bit          locked_m = 1'b0;

   function automatic void model_req(input bit we, input logic [31:0] addr,
                                     input logic [31:0] wd, input logic [3:0] strb,
                                     output bit err, output logic [31:0] rd);
      int unsigned w;
      w   = addr / 4;
      err = (addr % 4 != 0) || (w >= DEPTH) || (we && locked_m);
      rd  = 32'h0;
      if (!err) begin
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) mem_m[w][8*b +: 8] = wd[8*b +: 8];
         end else begin
            rd = mem_m[w];
         end
      end
   endfunction

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  strb;
   } req_t;

   typedef struct {
      bit          err;
      logic [31:0] rd;
   } rsp_t;

   req_t rq[$];
   rsp_t eq[$];
   int   n_stall = 0;

   function automatic req_t mk_req(input bit we, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [3:0] strb);
      req_t r;
      r.we = we; r.addr = addr; r.wd = wd; r.strb = strb;
      return r;
   endfunction

   // Single transaction: wait for acceptance, then for the response.
   task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, output bit err_o,
                         output logic [31:0] rd_o, output int lat);
      int w;
      bit me;
      logic [31:0] mr;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_strb = strb;
      rsp_ready = 1'b1;
      #1;
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk); #1; w++;
      end
      if (!req_ready) chk("req_accept_timeout", 32'(req_ready), 32'd1);
      model_req(we, addr, wd, strb, me, mr);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk); #1; lat++;
      end
      if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
      err_o = rsp_err;
      rd_o  = rsp_rdata;
   endtask

   // Stream engine. mode 0: always ready; 1: ready low 3 cycles after first
   // response; 2: random ready.
   task automatic stream(input int mode, input int max_cycles);
      int  cyc   = 0;
      int  hold  = 0;
      bit  first = 1'b0;
      bit  me;
      logic [31:0] mr;
      rsp_t e;
      n_stall = 0;
      while ((rq.size() > 0 || eq.size() > 0) && cyc < max_cycles) begin
         @(negedge clk);
         if (rq.size() > 0) begin
            req_valid = 1'b1; req_we = rq[0].we; req_addr = rq[0].addr;
            req_wdata = rq[0].wd; req_strb = rq[0].strb;
         end else begin
            req_valid = 1'b0;
         end
         if (mode == 0)      rsp_ready = 1'b1;
         else if (mode == 1) rsp_ready = (hold == 0);
         else                rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (rsp_valid) begin
            if (eq.size() == 0) begin
               chk("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
               chk("stream_rsp_err", 32'(rsp_err), 32'(eq[0].err));
               chk("stream_rsp_rdata", rsp_rdata, eq[0].rd);
               if (rsp_ready) begin
                  void'(eq.pop_front());
                  if (mode == 1 && !first) begin first = 1'b1; hold = 3; end
               end else begin
                  n_stall++;
                  chk("req_ready_in_stall", 32'(req_ready), 32'd0);
               end
            end
         end
         if (mode == 1 && hold > 0 && !rsp_ready) hold--;
         if (req_valid && req_ready) begin
            model_req(rq[0].we, rq[0].addr, rq[0].wd, rq[0].strb, me, mr);
            e.err = me; e.rd = mr;
            eq.push_back(e);
            void'(rq.pop_front());
         end
         cyc++;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      if (rq.size() != 0 || eq.size() != 0)
         chk("stream_timeout", 32'(rq.size() + eq.size()), 32'd0);
      rq.delete();
      eq.delete();
      repeat (4) begin
         @(negedge clk); #1;
         chk("no_extra_rsp", 32'(rsp_valid), 32'd0);
      end
   endtask

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  strb;
      bit          eerr;
      logic [31:0] erd;
   } vec_t;

   function automatic vec_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] strb, input bit eerr, input logic [31:0] erd);
      vec_t v;
      v.we = we; v.addr = addr; v.wd = wd; v.strb = strb; v.eerr = eerr; v.erd = erd;
      return v;
   endfunction

   vec_t        vt[$];
   bit          t_err;
   logic [31:0] t_rd;
   int          t_lat;
   logic [31:0] old0;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_strb = '0; rsp_ready = 1'b1;
`ifdef ROM_BANK_WPROT_EN
      wp_lock = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd1);

      // Initialise every word so the model and array agree.
      for (int w = 0; w < DEPTH; w++) rq.push_back(mk_req(1'b1, 32'(w * 4), $urandom, 4'hF));
      stream(0, 1000);

      // ---- table-driven single transactions ----
      vt.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0));
      vt.push_back(mk(1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF));
      vt.push_back(mk(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, 1'b0, 32'h0));
      vt.push_back(mk(1'b1, 32'h20, 32'h11223344, 4'h5, 1'b0, 32'h0));
      vt.push_back(mk(1'b0, 32'h20, 32'h0,        4'h0, 1'b0, 32'hAA22AA44));
      vt.push_back(mk(1'b0, 32'h12, 32'h0,        4'h0, 1'b1, 32'h0));
      vt.push_back(mk(1'b0, DEPTH * 4, 32'h0,     4'h0, 1'b1, 32'h0));
      vt.push_back(mk(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0));
      vt.push_back(mk(1'b1, DEPTH * 4, 32'h1234,  4'hF, 1'b1, 32'h0));
      vt.push_back(mk(1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF));
      vt.push_back(mk(1'b1, 32'h24, 32'h0BADF00D, 4'hF, 1'b0, 32'h0));
      vt.push_back(mk(1'b1, 32'h24, 32'h12345678, 4'h0, 1'b0, 32'h0));
      vt.push_back(mk(1'b0, 32'h24, 32'h0,        4'h0, 1'b0, 32'h0BADF00D));
      vt.push_back(mk(1'b1, 32'hBC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0));
      vt.push_back(mk(1'b0, 32'hBC, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D));
      vt.push_back(mk(1'b0, 32'hFFFFFFFC, 32'h0,  4'h0, 1'b1, 32'h0));
      vt.push_back(mk(1'b0, 32'h20, 32'h0,        4'h0, 1'b0, 32'hAA22AA44));
      foreach (vt[i]) begin
         do_req(vt[i].we, vt[i].addr, vt[i].wd, vt[i].strb, t_err, t_rd, t_lat);
         chk($sformatf("vec%0d_err", i), 32'(t_err), 32'(vt[i].eerr));
         chk($sformatf("vec%0d_rdata", i), t_rd, vt[i].erd);
         chk($sformatf("vec%0d_latency", i), 32'(t_lat), 32'(RL));
      end

      // ---- four back-to-back reads with a 3-cycle response stall ----
      rq.push_back(mk_req(1'b0, 32'h10, 32'h0, 4'h0));
      rq.push_back(mk_req(1'b0, 32'h20, 32'h0, 4'h0));
      rq.push_back(mk_req(1'b0, 32'hBC, 32'h0, 4'h0));
      rq.push_back(mk_req(1'b0, 32'h24, 32'h0, 4'h0));
      stream(1, 100);
      chk("backpressure_stall_cycles", 32'(n_stall), 32'd3);

      // ---- reset with two reads in flight ----
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
      @(negedge clk);
      req_addr = 32'h20;
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b1;
      #1;
      chk("inflight_before_rst", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      rst = 1'b0; rsp_ready = 1'b1;
      #1;
      chk("rst_flush_valid", 32'(rsp_valid), 32'd0);
      chk("rst_flush_err", 32'(rsp_err), 32'd0);
      chk("rst_flush_rdata", rsp_rdata, 32'd0);
      chk("rst_flush_ready", 32'(req_ready), 32'd1);
      repeat (5) begin
         @(negedge clk); #1;
         chk("rst_no_stale", 32'(rsp_valid), 32'd0);
      end
      do_req(1'b0, 32'h10, 32'h0, 4'h0, t_err, t_rd, t_lat);
      chk("rst_data_intact_10", t_rd, 32'hDEADBEEF);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, t_err, t_rd, t_lat);
      chk("rst_data_intact_20", t_rd, 32'hAA22AA44);

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 300; n++) begin
         int sel;
         logic [31:0] a;
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         else if (sel == 1) a = 32'((DEPTH + $urandom_range(0, 200)) * 4);
         else               a = 32'($urandom_range(0, DEPTH - 1) * 4);
         rq.push_back(mk_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15))));
      end
      stream(2, 5000);

`ifdef ROM_BANK_WPROT_EN
      // ---- write protect ----
      old0 = mem_m[0];
      @(negedge clk);
      wp_lock = 1'b1;
      @(negedge clk);
      wp_lock = 1'b0;
      locked_m = 1'b1;
      do_req(1'b1, 32'h0, 32'h55, 4'hF, t_err, t_rd, t_lat);
      chk("wprot_write_err", 32'(t_err), 32'd1);
      chk("wprot_write_rdata", t_rd, 32'd0);
      do_req(1'b0, 32'h0, 32'h0, 4'h0, t_err, t_rd, t_lat);
      chk("wprot_read_err", 32'(t_err), 32'd0);
      chk("wprot_read_old", t_rd, old0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
